// File: rtl/axi_sram_slave.sv
// AXI3 slave serving bursts from an internal word-addressed RAM, with independent read/write FSMs.
// Optional macro AXI_SLV_DELAY_EN inserts DELAY wait cycles before the first R beat and before B.
module axi_sram_slave #(
  parameter int MEM_AW = 16,
  parameter int DELAY  = 3
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  r_state_o,
  output logic [1:0]  w_state_o
);
  localparam int DEPTH = 1 << MEM_AW;

  // Valid/ready: a transfer happens on a rising edge where both are high; a raised valid
  // (and its payload) is held until that edge.
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

  r_state_e          r_state_q;
  w_state_e          w_state_q;
  logic [31:0]       mem [DEPTH];
  logic [MEM_AW-1:0] raddr_q, waddr_q, raddr_nxt, waddr_nxt, ar_idx, aw_idx;
  logic [7:0]        rlen_q, rbeat_q, wlen_q, wbeat_q;
  logic              rfixed_q, wfixed_q, werr_q, w_err_nxt, w_fire;
  logic              r_wait_done, w_wait_done;
  logic              unused_in;

  assign ar_idx    = araddr[MEM_AW+1:2];
  assign aw_idx    = awaddr[MEM_AW+1:2];
  assign raddr_nxt = rfixed_q ? raddr_q : raddr_q + MEM_AW'(1);
  assign waddr_nxt = wfixed_q ? waddr_q : waddr_q + MEM_AW'(1);
  assign w_fire    = (w_state_q == W_DATA) && wvalid && wready;
  // Error is sticky: wlast on the wrong beat, or reaching awlen without wlast.
  assign w_err_nxt = werr_q | (wlast != (wbeat_q == wlen_q));
  assign rresp     = 2'b00;
  assign r_state_o = r_state_q;
  assign w_state_o = w_state_q;
  assign unused_in = ^{wid, arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot,
                       araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

`ifdef AXI_SLV_DELAY_EN
  localparam bit WAIT_SKIP = (DELAY == 0);
  localparam logic [7:0] DLY_M1 = 8'(DELAY - 1);
  logic [7:0] rcnt_q, wcnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rcnt_q <= 8'd0;
      wcnt_q <= 8'd0;
    end else begin
      if (r_state_q == R_IDLE) rcnt_q <= DLY_M1;
      else if (r_state_q == R_WAIT && rcnt_q != 8'd0) rcnt_q <= rcnt_q - 8'd1;
      if (w_state_q == W_DATA) wcnt_q <= DLY_M1;
      else if (w_state_q == W_WAIT && wcnt_q != 8'd0) wcnt_q <= wcnt_q - 8'd1;
    end
  end
  assign r_wait_done = (rcnt_q == 8'd0);
  assign w_wait_done = (wcnt_q == 8'd0);
`else
  localparam bit WAIT_SKIP = 1'b1;
  assign r_wait_done = 1'b1;
  assign w_wait_done = 1'b1;
`endif

  // RAM has no reset so contents survive aresetn; reads in the FSM see pre-write data.
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[waddr_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rid       <= 4'd0;
      rdata     <= 32'd0;
      raddr_q   <= '0;
      rlen_q    <= 8'd0;
      rbeat_q   <= 8'd0;
      rfixed_q  <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready  <= 1'b0;
            rid      <= arid;
            raddr_q  <= ar_idx;
            rlen_q   <= arlen;
            rbeat_q  <= 8'd0;
            rfixed_q <= (arburst == 2'b00);
            if (WAIT_SKIP) begin
              r_state_q <= R_DATA;
              rvalid    <= 1'b1;
              rlast     <= (arlen == 8'd0);
              rdata     <= mem[ar_idx];
            end else begin
              r_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_wait_done) begin
            r_state_q <= R_DATA;
            rvalid    <= 1'b1;
            rlast     <= (rlen_q == 8'd0);
            rdata     <= mem[raddr_q];
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              r_state_q <= R_IDLE;
              rvalid    <= 1'b0;
              rlast     <= 1'b0;
              arready   <= 1'b1;
            end else begin
              raddr_q <= raddr_nxt;
              rbeat_q <= rbeat_q + 8'd1;
              rdata   <= mem[raddr_nxt];
              rlast   <= (rbeat_q + 8'd1 == rlen_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= 4'd0;
      bresp     <= 2'b00;
      waddr_q   <= '0;
      wlen_q    <= 8'd0;
      wbeat_q   <= 8'd0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready   <= 1'b0;
            wready    <= 1'b1;
            bid       <= awid;
            waddr_q   <= aw_idx;
            wlen_q    <= awlen;
            wbeat_q   <= 8'd0;
            wfixed_q  <= (awburst == 2'b00);
            werr_q    <= 1'b0;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            waddr_q <= waddr_nxt;
            wbeat_q <= wbeat_q + 8'd1;
            werr_q  <= w_err_nxt;
            if (wlast) begin
              wready <= 1'b0;
              if (WAIT_SKIP) begin
                w_state_q <= W_RESP;
                bvalid    <= 1'b1;
                bresp     <= w_err_nxt ? 2'b10 : 2'b00;
              end else begin
                w_state_q <= W_WAIT;
              end
            end
          end
        end
        W_WAIT: begin
          if (w_wait_done) begin
            w_state_q <= W_RESP;
            bvalid    <= 1'b1;
            bresp     <= werr_q ? 2'b10 : 2'b00;
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state_q <= W_IDLE;
            bvalid    <= 1'b0;
            awready   <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: fixed vector table, hand-written burst/reset sequences and random traffic
// checked against a word-array memory model.
module tb_axi_sram_slave;
  localparam int MEM_AW = 8;
  localparam int DEPTH  = 1 << MEM_AW;
  localparam int DLY    = 3;
`ifdef AXI_SLV_DELAY_EN
  localparam int EXP_LAT = (DLY == 0) ? 1 : DLY + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic        aclk, aresetn;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0]  unused_r_state, unused_w_state;

  axi_sram_slave #(.MEM_AW(MEM_AW), .DELAY(DLY)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .r_state_o(unused_r_state), .w_state_o(unused_w_state)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];

  typedef struct {
    logic [3:0]  id;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] addr, input logic [1:0] burst, input int k);
    logic [31:0] a;
    a = (burst == 2'b00) ? addr : addr + 32'(4 * k);
    return int'(a >> 2) % DEPTH;
  endfunction

  task automatic push_model(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    exp_q.delete();
    for (int k = 0; k <= int'(len); k++) exp_q.push_back(ref_mem[widx(addr, burst, k)]);
  endtask

  // Write burst using wd_q/ws_q as beat data; nbeats != len+1 exercises wrong-wlast handling.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input bit gaps);
    int n, k, cyc, lat, hold, idx;
    logic [1:0] exp_resp;
    exp_resp = (nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge aclk); n++; end
    if (!awready) begin chk("aw_timeout", 32'd0, 32'd1); awvalid = 1'b0; return; end
    @(negedge aclk);
    awvalid = 1'b0;
    chk("w_ready_after_aw", wready, 1);
    k = 0; cyc = 0;
    while (k < nbeats && cyc < 5000) begin
      wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      wdata  = wd_q[k];
      wstrb  = ws_q[k];
      wlast  = (k == nbeats - 1);
      if (wvalid && wready) begin
        idx = widx(addr, burst, k);
        for (int b = 0; b < 4; b++)
          if (ws_q[k][b]) ref_mem[idx][8*b +: 8] = wd_q[k][8*b +: 8];
        k++;
      end
      @(negedge aclk);
      cyc++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (k < nbeats) chk("w_timeout", k, nbeats);
    lat = 1;
    while (!bvalid && lat < 200) begin @(negedge aclk); lat++; end
    chk("b_latency", lat, EXP_LAT);
    chk("w_ready_low", wready, 0);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin @(negedge aclk); chk("b_hold", bvalid, 1); end
    chk("b_resp", bresp, exp_resp);
    chk("b_id", bid, id);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("b_done", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  // Read burst; expected beats come from exp_q. mode 0: rready=1, 1: toggle 1,0,.., 2: random.
  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int mode);
    int n, beat, cyc, lat;
    bit held;
    logic [31:0] held_data, exp_v;
    logic held_last;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge aclk); n++; end
    if (!arready) begin chk("ar_timeout", 32'd0, 32'd1); arvalid = 1'b0; return; end
    @(negedge aclk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 200) begin @(negedge aclk); lat++; end
    chk("r_latency", lat, EXP_LAT);
    beat = 0; cyc = 0; held = 0; held_data = '0; held_last = 1'b0;
    while (beat <= int'(len) && cyc < 5000) begin
      if (held) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, held_data);
        chk("r_hold_last", rlast, held_last);
      end
      case (mode)
        0: rready = 1'b1;
        1: rready = (cyc % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      held = 0;
      if (rvalid) begin
        if (rready) begin
          exp_v = exp_q.pop_front();
          chk("r_data", rdata, exp_v);
          chk("r_last", rlast, beat == int'(len));
          chk("r_id", rid, id);
          chk("r_resp", rresp, 0);
          beat++;
        end else begin
          held = 1; held_data = rdata; held_last = rlast;
        end
      end
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    if (beat <= int'(len)) chk("r_timeout", beat, int'(len) + 1);
    chk("r_done_rvalid", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, nb;
    logic [31:0] a;
    logic [1:0] bu;
    aresetn = 1'b0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; arlock = 0; arcache = 0;
    arprot = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01; awlock = 0; awcache = 0;
    awprot = 0; awvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;

    vecs[0] = '{4'h3, 32'h100, 32'hDEADBEEF, 4'hF, 32'h100, 32'hDEADBEEF};
    vecs[1] = '{4'h5, 32'h100, 32'h11223344, 4'h5, 32'h100, 32'hDE22BE44};
    vecs[2] = '{4'h7, 32'h100, 32'hAABBCCDD, 4'h0, 32'h100, 32'hDE22BE44};
    vecs[3] = '{4'h9, 32'h100, 32'h55667788, 4'hA, 32'h100, 32'h55227744};
    vecs[4] = '{4'hA, 32'h504, 32'hCAFEF00D, 4'hF, 32'h104, 32'hCAFEF00D};
    vecs[5] = '{4'hF, 32'h500, 32'h000000EE, 4'h1, 32'h100, 32'h552277EE};

    repeat (3) @(negedge aclk);
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_arready", arready, 1);
    chk("post_rst_awready", awready, 1);

    // Fill the whole RAM with one maximum-length burst so every read has a known value.
    wd_q.delete(); ws_q.delete();
    for (int k = 0; k < DEPTH; k++) begin wd_q.push_back($urandom()); ws_q.push_back(4'hF); end
    axi_write(4'h1, 32'h0, 8'd255, 2'b01, DEPTH, 0);

    for (int v = 0; v < 6; v++) begin
      wd_q.delete(); ws_q.delete();
      wd_q.push_back(vecs[v].wdata); ws_q.push_back(vecs[v].wstrb);
      axi_write(vecs[v].id, vecs[v].waddr, 8'd0, 2'b01, 1, 0);
      exp_q.delete();
      exp_q.push_back(vecs[v].exp);
      axi_read(vecs[v].id, vecs[v].raddr, 8'd0, 2'b01, 0);
    end

    // INCR burst of 4 with rready toggling.
    wd_q = '{32'd1, 32'd2, 32'd3, 32'd4}; ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'h2, 32'h200, 8'd3, 2'b01, 4, 0);
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    axi_read(4'h4, 32'h200, 8'd3, 2'b01, 1);

    // Early wlast on beat 1 of a 4-beat burst; later beats keep their old contents.
    wd_q = '{32'hA0A0A0A0, 32'hA1A1A1A1}; ws_q = '{4'hF, 4'hF};
    axi_write(4'h1, 32'h300, 8'd3, 2'b01, 2, 0);
    push_model(32'h300, 8'd3, 2'b01);
    axi_read(4'h1, 32'h300, 8'd3, 2'b01, 0);

    // wlast missing at awlen: burst runs one beat long, all beats written.
    wd_q = '{32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2}; ws_q = '{4'hF, 4'hF, 4'hF};
    axi_write(4'h6, 32'h340, 8'd1, 2'b01, 3, 1);
    push_model(32'h340, 8'd2, 2'b01);
    axi_read(4'h6, 32'h340, 8'd2, 2'b01, 2);

    // FIXED burst merges all beats into one word.
    wd_q = '{32'h11111111, 32'h22222222, 32'h33333333}; ws_q = '{4'hF, 4'h3, 4'h4};
    axi_write(4'h8, 32'h380, 8'd2, 2'b00, 3, 0);
    exp_q = '{32'h11332222, 32'h11332222, 32'h11332222};
    axi_read(4'h8, 32'h380, 8'd2, 2'b00, 2);

    // Concurrent write and read on disjoint regions.
    wd_q.delete(); ws_q.delete();
    for (int k = 0; k < 8; k++) begin wd_q.push_back($urandom()); ws_q.push_back(4'hF); end
    push_model(32'h280, 8'd7, 2'b01);
    fork
      axi_write(4'h3, 32'h0, 8'd7, 2'b01, 8, 1);
      axi_read(4'h4, 32'h280, 8'd7, 2'b01, 2);
    join

    // Reset asserted while beat 2 of an 8-beat read is on the bus.
    push_model(32'h40, 8'd7, 2'b01);
    @(negedge aclk);
    arid = 4'hC; araddr = 32'h40; arlen = 8'd7; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      n = 0;
      while (!rvalid && n < 200) begin @(negedge aclk); n++; end
      chk("rst_seq_data", rdata, exp_q.pop_front());
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
    end
    chk("rst_seq_beat2_valid", rvalid, 1);
    chk("rst_seq_beat2_data", rdata, exp_q[0]);
    aresetn = 1'b0;
    #1;
    chk("rst_seq_rvalid", rvalid, 0);
    chk("rst_seq_rlast", rlast, 0);
    chk("rst_seq_arready", arready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_seq_arready_back", arready, 1);
    chk("rst_seq_awready_back", awready, 1);
    push_model(32'h44, 8'd3, 2'b01);
    axi_read(4'hD, 32'h44, 8'd3, 2'b01, 2);

    // Random traffic against the memory model, including aliased upper address bits.
    for (int t = 0; t < 40; t++) begin
      a   = $urandom() & 32'hFFFF_FFFC;
      len = $urandom_range(0, 7);
      bu  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(0, 5);
        if (n == 0 && len > 0) nb = $urandom_range(1, len);
        else if (n == 1) nb = len + 2;
        else nb = len + 1;
        wd_q.delete(); ws_q.delete();
        for (int k = 0; k < nb; k++) begin
          wd_q.push_back($urandom());
          ws_q.push_back(4'($urandom_range(0, 15)));
        end
        axi_write(4'($urandom_range(0, 15)), a, 8'(len), bu, nb, 1);
      end else begin
        push_model(a, 8'(len), bu);
        axi_read(4'($urandom_range(0, 15)), a, 8'(len), bu, 2);
      end
    end

    repeat (2) @(negedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 responder that serves the CPU core's AXI master port from an internal word-addressed RAM. It is the memory-side end of the core's single AXI interface: it accepts read and write bursts, returns read data beats and write responses, and runs read and write channels independently. Used as the simulation and FPGA memory behind the CPU top, replacing an external interconnect for core bring-up.

## Interface
Parameters:
- MEM_AW, 16, log2 of RAM depth in 32-bit words; address bits [MEM_AW+1:2] index the RAM, upper bits are ignored (aliasing).
- DELAY, 3, extra response latency in cycles; used only when AXI_SLV_DELAY_EN is defined.

Ports:
- One clock; reset is asynchronous and active-low. The clock is aclk and the reset is aresetn.
- aclk  in  1  clock; all state changes on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address; arlock/arcache/arprot in 2/4/3, ignored.
- arvalid in 1; arready out 1.
- rid out 4; rdata out 32; rresp out 2; rlast out 1; rvalid out 1; rready in 1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address; awlock/awcache/awprot in 2/4/3, ignored.
- awvalid in 1; awready out 1.
- wid in 4 (ignored); wdata in 32; wstrb in 4; wlast in 1; wvalid in 1; wready out 1.
- bid out 4; bresp out 2; bvalid out 1; bready in 1.

## Operation
- Handshake on any channel = valid & ready at a rising edge.
- Read FSM: R_IDLE (arready=1) -> AR handshake captures id, addr, len, burst; beat count cleared -> R_WAIT (delay counter) -> R_DATA (rvalid=1). In R_DATA each R handshake advances the beat; rlast=1 when beat==len; handshake with rlast -> R_IDLE.
- Write FSM: W_IDLE (awready=1) -> AW handshake captures id, addr, len, burst -> W_DATA (wready=1); each W handshake writes byte lanes selected by wstrb, advances address and beat; handshake with wlast -> W_WAIT -> W_RESP (bvalid=1); B handshake -> W_IDLE.
- Address step: burst 2'b00 (FIXED) holds the address; every other encoding increments by 4 per beat. size is ignored; reads always return the full word.
- rresp always 2'b00. rid/bid = captured arid/awid.
- bresp = 2'b10 (SLVERR) if wlast arrives on a beat other than beat==awlen, or if beat exceeds awlen without wlast (burst then terminates on the next wlast); otherwise 2'b00. Writes of all beats still occur.
- rdata is registered: loaded from RAM on entering R_DATA and on each R handshake not carrying rlast. RAM read-before-write: a W beat written in the same cycle as an rdata load is not visible in that load.
- rdata, rvalid, rlast hold stable while rvalid & ~rready; bvalid, bid, bresp hold while bvalid & ~bready.
- Reset mid-burst: both FSMs return to IDLE immediately; the partial burst is abandoned; RAM contents are retained.

## Timing
- Reset values: arready=0, awready=0, wready=0, rvalid=0, rlast=0, bvalid=0, rid=0, rdata=0, rresp=0, bid=0, bresp=0. arready and awready go to 1 on the first rising edge after aresetn deasserts.
- arready and awready drop in the cycle after their handshake; no back-to-back address acceptance (one outstanding read, one outstanding write).
- Read latency: first rvalid is asserted 1 cycle after the AR handshake (R_WAIT lasts zero cycles) without the macro; DELAY+1 cycles with it. Subsequent beats: one per cycle while rready=1.
- Write: wready asserted the cycle after the AW handshake; bvalid asserted 1 cycle after the wlast handshake (DELAY+1 with the macro).
- arready returns to 1 the cycle after the rlast handshake; awready the cycle after the B handshake.
- Read and write FSMs run concurrently with no mutual ordering.

## Configuration
- AXI_SLV_DELAY_EN defined: R_WAIT and W_WAIT each hold for DELAY cycles via a down-counter loaded on entry; DELAY=0 is equivalent to undefined.
- Undefined: counters are not built; WAIT states pass through in zero cycles.

## Test plan
- Single write awaddr=0x100, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, then read araddr=0x100, arlen=0 -> rdata=0xDEADBEEF, rlast=1, rresp=0, bresp=0, bid=awid.
- Partial strobe: word 0x100 = 0xDEADBEEF, write 0x11223344 with wstrb=4'b0101 -> read returns 0xDE22BE44.
- INCR read burst arlen=3 at 0x200 preloaded 1,2,3,4 with rready toggling 1,0,1,0 -> four beats 1,2,3,4, rdata held stable while rready=0, rlast only on 4th.
- Early wlast on awlen=3 at beat 1 -> bresp=2'b10, beats 0 and 1 written, awready back to 1 after B handshake.
- Macro defined, DELAY=3: AR handshake at cycle N -> rvalid first high at N+4; undefined -> N+1.
- aresetn pulled low during beat 2 of an 8-beat read -> rvalid=0 immediately; after release arready=1 next edge and a new read returns correct data.
